// File: rtl/stg_hazard_ctl_pkg.sv
// Shared sizes, scoreboard counter type and FSM encodings for the decode/execute
// hazard controller. HAZARD_SR_EN enables SR tracking in the top.
package stg_hazard_ctl_pkg;

    localparam int SIZE_TGT_GP = 3;
    localparam int HBIT_TGT_GP = SIZE_TGT_GP - 1;
    localparam int HBIT_SRC_GP = HBIT_TGT_GP;
    localparam int SIZE_TGT_SR = 2;
    localparam int HBIT_TGT_SR = SIZE_TGT_SR - 1;
    localparam int HBIT_SRC_SR = HBIT_TGT_SR;
    localparam int SIZE_SB_CNT = 2;
    localparam int HBIT_SB_CNT = SIZE_SB_CNT - 1;

    localparam logic [1:0] HZ_RUN   = 2'd0;
    localparam logic [1:0] HZ_STALL = 2'd1;
    localparam logic [1:0] HZ_FLUSH = 2'd2;

    typedef logic [HBIT_SB_CNT:0] sb_cnt_t;

endpackage

// File: rtl/stg_scoreboard.sv
// Per-register in-flight write counters with two combinational lookup ports.
// Port b also reports saturation, for the target-register check.
module stg_scoreboard
    import stg_hazard_ctl_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en,
    input  logic [IDX_W-1:0] inc_idx,
    input  logic             dec_en,
    input  logic [IDX_W-1:0] dec_idx,
    input  logic [IDX_W-1:0] rd_a_idx,
    input  logic [IDX_W-1:0] rd_b_idx,
    output logic             rd_a_pend,
    output logic             rd_b_pend,
    output logic             rd_b_full
);

    localparam int ENTRIES = 1 << IDX_W;

    sb_cnt_t [ENTRIES-1:0] cnt;
    sb_cnt_t [ENTRIES-1:0] cnt_nxt;

    // A retire against an empty entry is dropped, so a same-cycle issue still counts.
    always_comb begin
        cnt_nxt = cnt;
        for (int i = 0; i < ENTRIES; i++) begin
            logic inc, dec;
            inc = inc_en && (inc_idx == IDX_W'(i));
            dec = dec_en && (dec_idx == IDX_W'(i)) && (cnt[i] != '0);
            if (inc && !dec && (cnt[i] != '1))
                cnt_nxt[i] = cnt[i] + 1'b1;
            else if (dec && !inc)
                cnt_nxt[i] = cnt[i] - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt_nxt;
    end

    assign rd_a_pend = (cnt[rd_a_idx] != '0);
    assign rd_b_pend = (cnt[rd_b_idx] != '0);
    assign rd_b_full = (cnt[rd_b_idx] == '1);

    retire_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(dec_en && (cnt[dec_idx] == '0)));

endmodule

// File: rtl/stg_hazard_ctl.sv
// Issue/stall/flush sequencer between decode and execute, driven by a write scoreboard.
// Define HAZARD_SR_EN to add SR ports and SR hazard tracking.
module stg_hazard_ctl
    import stg_hazard_ctl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst_n,
    input  logic                 iw_id_valid,
    input  logic                 iw_src_gp_en,
    input  logic [HBIT_SRC_GP:0] iw_src_gp,
    input  logic                 iw_tgt_gp_en,
    input  logic [HBIT_TGT_GP:0] iw_tgt_gp,
`ifdef HAZARD_SR_EN
    input  logic                 iw_src_sr_en,
    input  logic [HBIT_SRC_SR:0] iw_src_sr,
    input  logic                 iw_tgt_sr_en,
    input  logic [HBIT_TGT_SR:0] iw_tgt_sr,
`endif
    input  logic                 iw_wb_gp_en,
    input  logic [HBIT_TGT_GP:0] iw_wb_gp,
`ifdef HAZARD_SR_EN
    input  logic                 iw_wb_sr_en,
    input  logic [HBIT_TGT_SR:0] iw_wb_sr,
`endif
    input  logic                 iw_branch_taken,
    output logic                 ow_issue,
    output logic                 ow_stall,
    output logic                 ow_flush,
    output logic [1:0]           ow_state,
    output logic [15:0]          ow_stall_cnt
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    logic [1:0] state, state_nxt;
    logic [2:0] fcnt, fcnt_nxt;
    logic       gp_src_pend, gp_tgt_pend, gp_tgt_full;
    logic       sr_hazard, hazard, in_flush, issue_raw, stall_raw;

    stg_scoreboard #(.IDX_W(SIZE_TGT_GP)) u_sb_gp (
        .clk       (iw_clk),
        .rst_n     (iw_rst_n),
        .inc_en    (ow_issue & iw_tgt_gp_en),
        .inc_idx   (iw_tgt_gp),
        .dec_en    (iw_wb_gp_en),
        .dec_idx   (iw_wb_gp),
        .rd_a_idx  (iw_src_gp),
        .rd_b_idx  (iw_tgt_gp),
        .rd_a_pend (gp_src_pend),
        .rd_b_pend (gp_tgt_pend),
        .rd_b_full (gp_tgt_full)
    );

`ifdef HAZARD_SR_EN
    logic sr_src_pend, sr_tgt_pend, sr_tgt_full;

    stg_scoreboard #(.IDX_W(SIZE_TGT_SR)) u_sb_sr (
        .clk       (iw_clk),
        .rst_n     (iw_rst_n),
        .inc_en    (ow_issue & iw_tgt_sr_en),
        .inc_idx   (iw_tgt_sr),
        .dec_en    (iw_wb_sr_en),
        .dec_idx   (iw_wb_sr),
        .rd_a_idx  (iw_src_sr),
        .rd_b_idx  (iw_tgt_sr),
        .rd_a_pend (sr_src_pend),
        .rd_b_pend (sr_tgt_pend),
        .rd_b_full (sr_tgt_full)
    );

    assign sr_hazard = (iw_src_sr_en & sr_src_pend) |
                       (iw_tgt_sr_en & (sr_tgt_pend | sr_tgt_full));
`else
    assign sr_hazard = 1'b0;
`endif

    // The target is read as well as written, so any pending write to it blocks issue.
    assign hazard = (iw_src_gp_en & gp_src_pend) |
                    (iw_tgt_gp_en & (gp_tgt_pend | gp_tgt_full)) |
                    sr_hazard;

    assign in_flush  = (state == HZ_FLUSH);
    assign issue_raw = iw_id_valid & ~hazard & ~iw_branch_taken & ~in_flush;
    assign stall_raw = iw_id_valid &  hazard & ~iw_branch_taken & ~in_flush;

    assign ow_issue = iw_rst_n & issue_raw;
    assign ow_stall = iw_rst_n & stall_raw;
    assign ow_flush = iw_rst_n & (in_flush | iw_branch_taken);
    assign ow_state = state;

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        if (iw_branch_taken) begin
            state_nxt = HZ_FLUSH;
            fcnt_nxt  = FLUSH_LOAD;
        end else begin
            case (state)
                HZ_RUN:   if (iw_id_valid & hazard) state_nxt = HZ_STALL;
                HZ_STALL: if (~hazard | ~iw_id_valid) state_nxt = HZ_RUN;
                HZ_FLUSH: begin
                    if (fcnt == '0) state_nxt = HZ_RUN;
                    else            fcnt_nxt  = fcnt - 1'b1;
                end
                default:  state_nxt = HZ_RUN;
            endcase
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state        <= HZ_RUN;
            fcnt         <= '0;
            ow_stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            if (ow_stall && (ow_stall_cnt != 16'hFFFF))
                ow_stall_cnt <= ow_stall_cnt + 16'd1;
        end
    end

endmodule
